// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock divider with deferred divisor
// load, global sync restart and registered divided-clock/tick outputs.
module freq_div_multi #(
  parameter int CH      = 4,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 6,
  parameter int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic             sync,
  input  logic             load,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [DIV_W-1:0] load_div,
  output logic [CH-1:0]    clk_div,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    pend,
  output logic             load_err
);

  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  logic [CH-1:0] sel;
  logic          div_ok;
  logic          load_ok;

  // one-hot decode; out-of-range channels decode to all zeros
  always_comb begin
    sel = '0;
    for (int i = 0; i < CH; i++) begin
      sel[i] = (load_ch == CH_W'(i));
    end
  end

  assign div_ok  = (load_div >= TWO);
  assign load_ok = load & div_ok & (|sel);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] act_n;
    logic [DIV_W-1:0] pdiv;
    logic [DIV_W-1:0] pdiv_n;
    logic [DIV_W-1:0] d_app;
    logic             pnd;
    logic             pnd_n;
    logic             run;
    logic             ld;
    logic             wrap;
    logic             idle;
    logic             start;
    logic             wr;
    logic             step;
    logic             cdiv_q;
    logic             cdiv_n;
    logic             tick_q;
    logic             tick_n;

    assign ld    = load_ok & sel[g];
    assign d_app = pnd ? pdiv : act;
    assign wrap  = (cnt == act - ONE);

    // disabled or sync: boundary; first enabled edge: start period
    assign idle  = ~en[g] | sync;
    assign start = en[g] & ~sync & ~run;
    assign wr    = en[g] & ~sync & run & wrap;
    assign step  = en[g] & ~sync & run & ~wrap;

    always_comb begin
      cnt_n  = cnt;
      act_n  = act;
      pdiv_n = pdiv;
      pnd_n  = pnd;
      unique case (1'b1)
        idle: begin
          cnt_n = '0;
          act_n = d_app;
          pnd_n = 1'b0;
        end
        start: begin
          cnt_n = '0;
        end
        wr: begin
          cnt_n = '0;
          pnd_n = 1'b0;
          act_n = ld ? load_div : d_app;
        end
        step: begin
          cnt_n = cnt + ONE;
        end
        default: begin
          cnt_n = cnt;
        end
      endcase
      // a load on a wrap edge bypassed pend above
      if (ld && !wr) begin
        pdiv_n = load_div;
        pnd_n  = 1'b1;
      end
    end

    assign cdiv_n = en[g] & (cnt_n < (act_n >> 1));
    assign tick_n = en[g] & (cnt_n == act_n - ONE);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt    <= '0;
        act    <= DEF;
        pdiv   <= DEF;
        pnd    <= 1'b0;
        run    <= 1'b0;
        cdiv_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt    <= cnt_n;
        act    <= act_n;
        pdiv   <= pdiv_n;
        pnd    <= pnd_n;
        run    <= en[g];
        cdiv_q <= cdiv_n;
        tick_q <= tick_n;
      end
    end

    assign clk_div[g] = cdiv_q;
    assign tick[g]    = tick_q;
    assign pend[g]    = pnd;
  end

endmodule

// File: tb/tb_freq_div_multi.sv
// Randomised bench for freq_div_multi: per-channel period model
// compared every cycle, plus hand-computed waveform pins.
module tb_freq_div_multi;

  localparam int CH    = 4;
  localparam int DIV_W = 8;
  localparam int DEF   = 6;
  localparam int CH_W  = 2;

  logic             clk;
  logic             rst;
  logic [CH-1:0]    en;
  logic             sync;
  logic             load;
  logic [CH_W-1:0]  load_ch;
  logic [DIV_W-1:0] load_div;
  logic [CH-1:0]    clk_div;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    pend;
  logic             load_err;

  int checks = 0;
  int errors = 0;

  freq_div_multi #(
    .CH(CH), .DIV_W(DIV_W), .DEF_DIV(DEF), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .load(load), .load_ch(load_ch), .load_div(load_div),
    .clk_div(clk_div), .tick(tick), .pend(pend),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: position in period, active and pending divisor
  int m_pos  [CH];
  int m_d    [CH];
  int m_pd   [CH];
  bit m_pnd  [CH];
  bit m_run  [CH];
  logic [CH-1:0] m_clk;
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_pend;
  logic          m_err;
  bit            m_ok;
  bit            m_ld;
  int            m_new;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        m_pos[i] = 0; m_d[i] = DEF; m_pd[i] = DEF;
        m_pnd[i] = 0; m_run[i] = 0;
      end
      m_clk = '0; m_tick = '0; m_pend = '0; m_err = 0;
    end else begin
      m_ok  = load && (int'(load_div) >= 2) && (int'(load_ch) < CH);
      m_err = load && !m_ok;
      for (int i = 0; i < CH; i++) begin
        m_ld = m_ok && (int'(load_ch) == i);
        if (!en[i] || sync) begin
          if (m_pnd[i]) m_d[i] = m_pd[i];
          m_pnd[i] = 0;
          m_pos[i] = 0;
          if (m_ld) begin m_pd[i] = int'(load_div); m_pnd[i] = 1; end
        end else if (!m_run[i]) begin
          m_pos[i] = 0;
          if (m_ld) begin m_pd[i] = int'(load_div); m_pnd[i] = 1; end
        end else if (m_pos[i] + 1 >= m_d[i]) begin
          m_new = m_pnd[i] ? m_pd[i] : m_d[i];
          if (m_ld) m_new = int'(load_div);
          m_d[i] = m_new;
          m_pnd[i] = 0;
          m_pos[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] + 1;
          if (m_ld) begin m_pd[i] = int'(load_div); m_pnd[i] = 1; end
        end
        m_run[i]  = en[i];
        m_clk[i]  = en[i] && (m_pos[i] < m_d[i] / 2);
        m_tick[i] = en[i] && (m_pos[i] == m_d[i] - 1);
        m_pend[i] = m_pnd[i];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("model_clk_div", 32'(clk_div), 32'(m_clk));
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_pend", 32'(pend), 32'(m_pend));
    chk("model_load_err", 32'(load_err), 32'(m_err));
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  int idx;

  initial begin
    rst = 1'b1; en = '0; sync = 0; load = 0;
    load_ch = '0; load_div = '0;
    #1 rst = 1'b0;
    repeat (3) nxt();
    chk("rst_clk_div", 32'(clk_div), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    rst = 1'b1;
    nxt();

    // default divide-by-6 on channel 0
    en = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      nxt();
      chk("d6_clk0", 32'(clk_div[0]), 32'(k % 6 < 3));
      chk("d6_tick0", 32'(tick[0]), 32'(k % 6 == 5));
      chk("d6_others", 32'(clk_div[3:1]), 32'd0);
    end

    // load ch1 while disabled
    load = 1; load_ch = 2'd1; load_div = 8'd5;
    nxt();
    load = 0;
    chk("ld_dis_pend1", 32'(pend[1]), 32'd1);
    nxt();
    chk("ld_dis_pend1_clr", 32'(pend[1]), 32'd0);
    en = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      nxt();
      chk("d5_clk1", 32'(clk_div[1]), 32'(k % 5 < 2));
    end

    // rejected loads
    load = 1; load_ch = 2'd0; load_div = 8'd1;
    nxt();
    chk("err_div1", 32'(load_err), 32'd1);
    load_div = 8'd0;
    nxt();
    load = 0;
    chk("err_div0", 32'(load_err), 32'd1);
    nxt();
    chk("err_clear", 32'(load_err), 32'd0);
    chk("err_no_pend", 32'(pend[0]), 32'd0);

    // ch2 at D=10, then sync all
    load = 1; load_ch = 2'd2; load_div = 8'd10;
    nxt();
    load = 0;
    nxt();
    en = 4'b0111;
    repeat (7) nxt();
    sync = 1;
    nxt();
    sync = 0;
    chk("sync_clk", 32'(clk_div[2:0]), 32'h7);
    chk("sync_tick", 32'(tick[2:0]), 32'h0);
    for (int k = 1; k <= 30; k++) begin
      nxt();
      if (k == 29) chk("sync_29", 32'(clk_div[0] | clk_div[2]), 32'd0);
    end
    chk("sync_30", 32'({clk_div[2], clk_div[0]}), 32'h3);

    // deferred change of ch0 from 6 to 4 mid-period
    load = 1; load_ch = 2'd0; load_div = 8'd4;
    for (int j = 1; j <= 13; j++) begin
      nxt();
      load = 0;
      if (j <= 5) begin
        chk("d4_pend", 32'(pend[0]), 32'd1);
        chk("d4_old", 32'(clk_div[0]), 32'(j < 3));
      end else begin
        chk("d4_pend_clr", 32'(pend[0]), 32'd0);
        chk("d4_new", 32'(clk_div[0]), 32'((j - 6) % 4 < 2));
      end
    end

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      load     = ($urandom_range(0, 3) == 0);
      load_ch  = CH_W'($urandom_range(0, CH - 1));
      load_div = ($urandom_range(0, 7) == 0) ?
                 DIV_W'($urandom_range(0, 255)) :
                 DIV_W'($urandom_range(0, 12));
      sync     = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 20) == 0) begin
        idx = int'($urandom_range(0, CH - 1));
        en[idx] = ~en[idx];
      end
      nxt();
    end

    // asynchronous reset with ch0 at D=4
    load = 0; sync = 0; en = 4'b0001;
    nxt();
    load = 1; load_ch = 2'd0; load_div = 8'd4;
    nxt();
    load = 0; sync = 1;
    nxt();
    sync = 0;
    chk("pre_rst_d4", 32'(clk_div[0]), 32'd1);
    nxt();
    #2 rst = 1'b0;
    #1;
    chk("async_clk", 32'(clk_div), 32'd0);
    chk("async_tick", 32'(tick), 32'd0);
    chk("async_pend", 32'(pend), 32'd0);
    nxt();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      nxt();
      chk("post_rst_clk0", 32'(clk_div[0]), 32'(k % 6 < 3));
      chk("post_rst_tick0", 32'(tick[0]), 32'(k % 6 == 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
